// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
//   phase_t    : decoder FSM state, named after the accepted {B,A} level
//   phase_of   : maps a {B,A} level onto its phase state
//   phase_idx  : position of a phase along the up sequence 00->01->11->10
package quad_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_DEF        = 2;

  typedef enum logic [2:0] {
    PH_INIT,
    PH_00,
    PH_01,
    PH_11,
    PH_10
  } phase_t;

  function automatic phase_t phase_of(input logic [1:0] ba);
    phase_t p;
    case (ba)
      2'b00:   p = PH_00;
      2'b01:   p = PH_01;
      2'b11:   p = PH_11;
      default: p = PH_10;
    endcase
    return p;
  endfunction

  // Index along the up sequence. Subtracting two indices modulo 4 yields
  // 1 for a forward quarter-step, 3 for a reverse one and 2 for a jump.
  function automatic logic [1:0] phase_idx(input phase_t p);
    logic [1:0] idx;
    case (p)
      PH_01:   idx = 2'd1;
      PH_11:   idx = 2'd2;
      PH_10:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/quad_if.sv
// Signal bundle used by the verification environment to reach the decoder.
//   clk            : shared clock (interface port)
//   rst_n .. err_clr : stimulus towards the decoder
//   pos .. err     : decoder results
interface quad_if #(
  parameter int WIDTH = 8
) (
  input logic clk
);

  logic             rst_n;
  logic             a_in;
  logic             b_in;
  logic             en;
  logic             clr;
  logic             err_clr;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             step;
  logic             wrap;
  logic             err;

  modport dut (
    input  clk, rst_n, a_in, b_in, en, clr, err_clr,
    output pos, dir, step, wrap, err
  );

endinterface

// File: rtl/quad_in_filter.sv
// Input conditioning for the two encoder phases.
// Each bit passes through a SYNC_STAGES-deep synchroniser; the synchronised
// {B,A} pair is accepted only once it has been seen FILT consecutive cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_i      : raw {B,A} from the pins (asynchronous)
//   val_o      : synchronised {B,A}; meaningful while new_val_o is high
//   new_val_o  : one-cycle strobe when a new stable level is accepted
//                (the first acceptance after reset always strobes)
module quad_in_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT        = FILT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] raw_i,
  output logic [1:0] val_o,
  output logic       new_val_o
);

  localparam int CNT_W = $clog2(FILT + 1);

  logic [1:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] prime_q;
  logic [1:0]             cand_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [1:0]             acc_q;
  logic                   acc_vld_q;
  logic [1:0]             samp;
  logic                   ready;
  logic                   accept;

  assign samp  = sync_q[SYNC_STAGES-1];
  // The synchroniser holds reset zeros until real samples have shifted all
  // the way through; counting those would accept a level that never existed
  // on the pins and could fake an illegal jump after reset.
  assign ready = prime_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = '0;
    accept = 1'b0;
    if (ready) begin
      if (samp == cand_q) begin
        cnt_d = (cnt_q < CNT_W'(FILT)) ? cnt_q + 1'b1 : cnt_q;
      end else begin
        cnt_d = CNT_W'(1);
      end
      accept = (cnt_d >= CNT_W'(FILT)) && (!acc_vld_q || (samp != acc_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 2'b00;
      end
      prime_q   <= '0;
      cand_q    <= 2'b00;
      cnt_q     <= '0;
      acc_q     <= 2'b00;
      acc_vld_q <= 1'b0;
    end else begin
      sync_q[0] <= raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      cand_q  <= samp;
      cnt_q   <= cnt_d;
      if (accept) begin
        acc_q     <= samp;
        acc_vld_q <= 1'b1;
      end
    end
  end

  assign val_o     = samp;
  assign new_val_o = accept;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder with wrapping position counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   a_in, b_in : encoder phases (asynchronous to clk)
//   en         : count enable (phase tracking continues when low)
//   clr        : synchronous clear of pos, wins over a coincident step
//   err_clr    : synchronous clear of err, loses to a coincident error
//   pos        : position, modulo 2^WIDTH
//   dir        : direction of the last accepted quarter-step (1 = up)
//   step       : one-cycle pulse per counted quarter-step
//   wrap       : one-cycle pulse when pos wraps
//   err        : sticky flag for two-bit (illegal) transitions
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT        = FILT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  logic [1:0]       flt_val;
  logic             flt_new;

  phase_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  phase_t           new_ph;
  logic [1:0]       delta;

  quad_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT        (FILT)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     ({b_in, a_in}),
    .val_o     (flt_val),
    .new_val_o (flt_new)
  );

  assign new_ph = phase_of(flt_val);
  assign delta  = phase_idx(new_ph) - phase_idx(state_q);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err_q && !err_clr;

    if (flt_new) begin
      state_d = new_ph;
      // From PH_INIT the first level only establishes the phase.
      if (state_q != PH_INIT) begin
        case (delta)
          2'd1: begin
            dir_d = 1'b1;
            if (en) begin
              step_d = 1'b1;
              wrap_d = (pos_q == '1);
              pos_d  = pos_q + 1'b1;
            end
          end
          2'd3: begin
            dir_d = 1'b0;
            if (en) begin
              step_d = 1'b1;
              wrap_d = (pos_q == '0);
              pos_d  = pos_q - 1'b1;
            end
          end
          2'd2: begin
            err_d = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end

    // Clear overrides the count but the step itself is still reported.
    if (clr) begin
      pos_d  = '0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_INIT;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  quad_if #(.WIDTH(8)) qif (.clk(clk));

  quad_decoder #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .FILT        (2)
  ) dut (
    .clk     (qif.clk),
    .rst_n   (qif.rst_n),
    .a_in    (qif.a_in),
    .b_in    (qif.b_in),
    .en      (qif.en),
    .clr     (qif.clr),
    .err_clr (qif.err_clr),
    .pos     (qif.pos),
    .dir     (qif.dir),
    .step    (qif.step),
    .wrap    (qif.wrap),
    .err     (qif.err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: position as a plain integer modulo 256, last accepted
  // {B,A} level, and the successor of each level in the up sequence
  // 00->01->11->10->00 (indexed by the level value).
  int         m_pos;
  logic       m_dir;
  logic       m_err;
  logic [1:0] m_ab;
  int         up_next [4] = '{1, 3, 0, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic es, input logic ew);
    logic [7:0] p;
    p = m_pos[7:0];
    chk({tag, ".pos"},  {24'd0, qif.pos}, {24'd0, p});
    chk({tag, ".dir"},  {31'd0, qif.dir},  {31'd0, m_dir});
    chk({tag, ".step"}, {31'd0, qif.step}, {31'd0, es});
    chk({tag, ".wrap"}, {31'd0, qif.wrap}, {31'd0, ew});
    chk({tag, ".err"},  {31'd0, qif.err},  {31'd0, m_err});
  endtask

  // Hold the current inputs for six cycles; no step may appear.
  task automatic settle(input string tag);
    repeat (6) begin
      tick();
      check_all(tag, 1'b0, 1'b0);
    end
  endtask

  // Called just after a rising edge. Applies the reset with the given
  // pin level, checks outputs clear without a clock edge, then releases.
  task automatic do_reset(input logic [1:0] ab);
    {qif.b_in, qif.a_in} = ab;
    qif.rst_n = 1'b0;
    #2;
    m_pos = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
    check_all("rst.async", 1'b0, 1'b0);
    tick();
    tick();
    qif.rst_n = 1'b1;
    m_ab = ab;
    settle("rst.init");
  endtask

  // Called just after a rising edge. Moves the pins to ab, holds six cycles
  // and checks the result on the fourth edge; clr/err_clr are presented on
  // that same edge when requested.
  task automatic step_to(input string tag, input logic [1:0] ab,
                         input logic en_v, input logic clr_v, input logic eclr_v);
    int   kind;
    logic es, ew;
    qif.en = en_v;
    {qif.b_in, qif.a_in} = ab;
    if (ab == m_ab)                 kind = 0;
    else if (up_next[m_ab] == ab)   kind = 1;
    else if (up_next[ab] == m_ab)   kind = 2;
    else                            kind = 3;

    repeat (3) begin
      tick();
      chk({tag, ".early_step"}, {31'd0, qif.step}, 32'd0);
    end
    qif.clr     = clr_v;
    qif.err_clr = eclr_v;
    tick();

    es = 1'b0;
    ew = 1'b0;
    if (eclr_v) m_err = 1'b0;
    case (kind)
      1: begin
        m_dir = 1'b1;
        if (en_v) begin
          es = 1'b1;
          ew = (m_pos == 255);
          m_pos = (m_pos + 1) % 256;
        end
      end
      2: begin
        m_dir = 1'b0;
        if (en_v) begin
          es = 1'b1;
          ew = (m_pos == 0);
          m_pos = (m_pos + 255) % 256;
        end
      end
      3: m_err = 1'b1;
      default: ;
    endcase
    if (clr_v) begin
      m_pos = 0;
      ew = 1'b0;
    end
    m_ab = ab;
    check_all(tag, es, ew);

    qif.clr     = 1'b0;
    qif.err_clr = 1'b0;
    tick();
    chk({tag, ".step_width"}, {31'd0, qif.step}, 32'd0);
    chk({tag, ".wrap_width"}, {31'd0, qif.wrap}, 32'd0);
    tick();
  endtask

  initial begin
    logic [1:0] rab;
    logic       ren, rclr, reclr;

    qif.rst_n   = 1'b0;
    qif.a_in    = 1'b0;
    qif.b_in    = 1'b0;
    qif.en      = 1'b1;
    qif.clr     = 1'b0;
    qif.err_clr = 1'b0;
    m_ab        = 2'b00;
    tick();
    do_reset(2'b00);

    // Forward counting
    step_to("fwd1", 2'b01, 1'b1, 1'b0, 1'b0);
    step_to("fwd2", 2'b11, 1'b1, 1'b0, 1'b0);
    step_to("fwd3", 2'b10, 1'b1, 1'b0, 1'b0);
    step_to("fwd4", 2'b00, 1'b1, 1'b0, 1'b0);

    // Reverse counting
    step_to("rev1", 2'b10, 1'b1, 1'b0, 1'b0);
    step_to("rev2", 2'b11, 1'b1, 1'b0, 1'b0);
    step_to("rev3", 2'b01, 1'b1, 1'b0, 1'b0);
    step_to("rev4", 2'b00, 1'b1, 1'b0, 1'b0);

    // Wrap both ways, then a step with counting disabled
    step_to("wrap_dn", 2'b10, 1'b1, 1'b0, 1'b0);
    step_to("wrap_up", 2'b00, 1'b1, 1'b0, 1'b0);
    step_to("en_off",  2'b01, 1'b0, 1'b0, 1'b0);

    // Illegal jump, error clear, position clear
    step_to("pre_ill", 2'b00, 1'b1, 1'b0, 1'b0);
    step_to("illegal", 2'b11, 1'b1, 1'b0, 1'b0);
    qif.err_clr = 1'b1;
    tick();
    qif.err_clr = 1'b0;
    m_err = 1'b0;
    check_all("err_clr", 1'b0, 1'b0);
    qif.clr = 1'b1;
    tick();
    qif.clr = 1'b0;
    m_pos = 0;
    check_all("clr", 1'b0, 1'b0);
    step_to("to7a", 2'b10, 1'b1, 1'b0, 1'b0);
    step_to("to7b", 2'b00, 1'b1, 1'b0, 1'b0);
    step_to("to7c", 2'b01, 1'b1, 1'b0, 1'b0);
    step_to("to7d", 2'b11, 1'b1, 1'b0, 1'b0);
    step_to("to7e", 2'b10, 1'b1, 1'b0, 1'b0);
    step_to("to7f", 2'b00, 1'b1, 1'b0, 1'b0);
    step_to("to7g", 2'b01, 1'b1, 1'b0, 1'b0);
    chk("pos_is_7", {24'd0, qif.pos}, 32'd7);
    step_to("clr_step", 2'b11, 1'b1, 1'b1, 1'b0);

    // Glitch rejection: one-cycle high pulse on A
    step_to("pre_glitch", 2'b10, 1'b1, 1'b0, 1'b0);
    qif.a_in = 1'b1;
    tick();
    qif.a_in = 1'b0;
    settle("glitch");

    // Reset in the middle of operation with the pins at 11
    step_to("pre_rst1", 2'b11, 1'b1, 1'b0, 1'b0);
    step_to("pre_rst2", 2'b01, 1'b1, 1'b0, 1'b0);
    step_to("pre_rst3", 2'b11, 1'b1, 1'b0, 1'b0);
    do_reset(2'b11);
    step_to("post_rst", 2'b10, 1'b1, 1'b0, 1'b0);

    // Randomised transitions, including illegal jumps and control pulses
    repeat (40) begin
      rab   = 2'($urandom_range(0, 3));
      ren   = ($urandom_range(0, 4) != 0);
      rclr  = ($urandom_range(0, 9) == 0);
      reclr = ($urandom_range(0, 5) == 0);
      step_to("rand", rab, ren, rclr, reclr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
